// File: rtl/npe_conv_seq.sv
// -----------------------------------------------------------------------------
// npe_conv_seq
// Layer-level sequencer for the NPE PE controller. A legal configuration is
// latched on i_start and the whole layer then runs without software help:
//   LOAD  : consume acc_len operand beats per output group (o_mdata_req)
//   FLUSH : fire one output strobe, then give the PE output walker time
//   DRAIN : wait until every expected result beat has come back
//   DONE  : one-cycle o_done pulse, then back to IDLE
//
// Optional feature (macro NPE_SEQ_PERF_EN): adds o_stall_cnt, a saturating
// 32-bit count of LOAD cycles with i_data_rdy low. It is cleared on an
// accepted start and holds its value after done.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_start             start pulse, ignored while o_busy=1
//   i_cfg_mode          1=mac, 2=fc, 4=max, 5=acc (others illegal)
//   i_cfg_pe_num        active MAC banks 1..7 (mac mode only)
//   i_cfg_acc_len       accumulate beats per output group (>=1)
//   i_cfg_out_cnt       output groups per layer (>=1)
//   i_data_rdy          operand beat available this cycle
//   i_npe_result_vld    result beat returned by the PE controller
//   o_busy, o_done      activity flag, completion pulse
//   o_cfg_err           pulse when a start carries an illegal config
//   o_npe_mode          latched mode, 0 when idle
//   o_pe_en             bank enable mask
//   o_mdata_req         operand beat consumed
//   o_pe_conv_out       output strobe, mac mode
//   o_pe_fc_out         output strobe, fc mode
//   o_pe_max_out        output strobe, max and acc modes
//   o_stall_cnt         (NPE_SEQ_PERF_EN only) LOAD stall cycles
// -----------------------------------------------------------------------------
module npe_conv_seq #(
    parameter int CNT_W   = 16,
    parameter int NUM_MAC = 7
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [2:0]         i_cfg_mode,
    input  logic [2:0]         i_cfg_pe_num,
    input  logic [CNT_W-1:0]   i_cfg_acc_len,
    input  logic [CNT_W-1:0]   i_cfg_out_cnt,
    input  logic               i_data_rdy,
    input  logic               i_npe_result_vld,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err,
    output logic [2:0]         o_npe_mode,
    output logic [NUM_MAC-1:0] o_pe_en,
    output logic               o_mdata_req,
    output logic               o_pe_conv_out,
    output logic               o_pe_fc_out,
    output logic               o_pe_max_out
`ifdef NPE_SEQ_PERF_EN
    ,
    output logic [31:0]        o_stall_cnt
`endif
);

    localparam int RES_W = CNT_W + 3;

    localparam logic [2:0] MODE_MAC = 3'd1;
    localparam logic [2:0] MODE_FC  = 3'd2;
    localparam logic [2:0] MODE_MAX = 3'd4;
    localparam logic [2:0] MODE_ACC = 3'd5;

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, DRAIN, DONE} state_e;

    state_e             state_q,     state_d;
    logic [2:0]         mode_q,      mode_d;
    logic [2:0]         flush_len_q, flush_len_d;
    logic [CNT_W-1:0]   acc_len_q,   acc_len_d;
    logic [CNT_W-1:0]   out_cnt_q,   out_cnt_d;
    logic [CNT_W-1:0]   acc_cnt_q,   acc_cnt_d;
    logic [CNT_W-1:0]   out_grp_q,   out_grp_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic [RES_W-1:0]   res_exp_q,   res_exp_d;
    logic [RES_W-1:0]   res_cnt_q,   res_cnt_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cfg_err_q,   cfg_err_d;
    logic [NUM_MAC-1:0] pe_en_q,     pe_en_d;
    logic               conv_q,      conv_d;
    logic               fc_q,        fc_d;
    logic               max_q,       max_d;
`ifdef NPE_SEQ_PERF_EN
    logic [31:0]        stall_q,     stall_d;
`endif

    logic               cfg_is_mac;
    logic               cfg_legal;
    logic [NUM_MAC:0]   pe_onehot;
    logic [NUM_MAC-1:0] pe_therm;

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        mode_d      = mode_q;
        flush_len_d = flush_len_q;
        acc_len_d   = acc_len_q;
        out_cnt_d   = out_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        out_grp_d   = out_grp_q;
        flush_cnt_d = flush_cnt_q;
        res_exp_d   = res_exp_q;
        res_cnt_d   = res_cnt_q;
        busy_d      = busy_q;
        pe_en_d     = pe_en_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        conv_d      = 1'b0;
        fc_d        = 1'b0;
        max_d       = 1'b0;
`ifdef NPE_SEQ_PERF_EN
        stall_d     = stall_q;
`endif

        cfg_is_mac = (i_cfg_mode == MODE_MAC);
        cfg_legal  = (cfg_is_mac || (i_cfg_mode == MODE_FC) ||
                      (i_cfg_mode == MODE_MAX) || (i_cfg_mode == MODE_ACC)) &&
                     (i_cfg_acc_len != '0) && (i_cfg_out_cnt != '0) &&
                     !(cfg_is_mac && (i_cfg_pe_num == 3'd0));
        // Thermometer mask: (1 << pe_num) - 1, truncated to the bank count.
        pe_onehot  = (NUM_MAC+1)'(1) << i_cfg_pe_num;
        pe_therm   = NUM_MAC'(pe_onehot - (NUM_MAC+1)'(1));

        // Result beats are counted for the whole busy period, including ones
        // that return before DRAIN, and saturate at the expected total.
        if (busy_q && i_npe_result_vld && (res_cnt_q < res_exp_q)) begin
            res_cnt_d = res_cnt_q + RES_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (cfg_legal) begin
                        state_d     = LOAD;
                        busy_d      = 1'b1;
                        mode_d      = i_cfg_mode;
                        acc_len_d   = i_cfg_acc_len;
                        out_cnt_d   = i_cfg_out_cnt;
                        flush_len_d = cfg_is_mac ? i_cfg_pe_num : 3'd1;
                        pe_en_d     = cfg_is_mac ? pe_therm : NUM_MAC'(1);
                        res_exp_d   = RES_W'(i_cfg_out_cnt) *
                                      RES_W'(cfg_is_mac ? i_cfg_pe_num : 3'd1);
                        acc_cnt_d   = '0;
                        out_grp_d   = '0;
                        flush_cnt_d = '0;
                        res_cnt_d   = '0;
`ifdef NPE_SEQ_PERF_EN
                        stall_d     = '0;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (i_data_rdy) begin
                    if (acc_cnt_q == acc_len_q - CNT_W'(1)) begin
                        acc_cnt_d   = '0;
                        flush_cnt_d = '0;
                        state_d     = FLUSH;
                        // Strobe is registered so it lands on the first FLUSH cycle.
                        conv_d      = (mode_q == MODE_MAC);
                        fc_d        = (mode_q == MODE_FC);
                        max_d       = (mode_q == MODE_MAX) || (mode_q == MODE_ACC);
                    end else begin
                        acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    end
                end else begin
`ifdef NPE_SEQ_PERF_EN
                    if (stall_q != '1) begin
                        stall_d = stall_q + 32'd1;
                    end
`endif
                end
            end
            FLUSH: begin
                if (flush_cnt_q == flush_len_q - 3'd1) begin
                    flush_cnt_d = '0;
                    out_grp_d   = out_grp_q + CNT_W'(1);
                    state_d     = (out_grp_q == out_cnt_q - CNT_W'(1)) ? DRAIN : LOAD;
                end else begin
                    flush_cnt_d = flush_cnt_q + 3'd1;
                end
            end
            DRAIN: begin
                // Uses the next count so a beat arriving this cycle finishes the layer.
                if (res_cnt_d == res_exp_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                mode_d  = 3'd0;
                pe_en_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            flush_len_q <= '0;
            acc_len_q   <= '0;
            out_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            out_grp_q   <= '0;
            flush_cnt_q <= '0;
            res_exp_q   <= '0;
            res_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            pe_en_q     <= '0;
            conv_q      <= 1'b0;
            fc_q        <= 1'b0;
            max_q       <= 1'b0;
`ifdef NPE_SEQ_PERF_EN
            stall_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            mode_q      <= mode_d;
            flush_len_q <= flush_len_d;
            acc_len_q   <= acc_len_d;
            out_cnt_q   <= out_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            out_grp_q   <= out_grp_d;
            flush_cnt_q <= flush_cnt_d;
            res_exp_q   <= res_exp_d;
            res_cnt_q   <= res_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            pe_en_q     <= pe_en_d;
            conv_q      <= conv_d;
            fc_q        <= fc_d;
            max_q       <= max_d;
`ifdef NPE_SEQ_PERF_EN
            stall_q     <= stall_d;
`endif
        end
    end

    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_cfg_err     = cfg_err_q;
    assign o_npe_mode    = mode_q;
    assign o_pe_en       = pe_en_q;
    assign o_mdata_req   = (state_q == LOAD) && i_data_rdy;
    assign o_pe_conv_out = conv_q;
    assign o_pe_fc_out   = fc_q;
    assign o_pe_max_out  = max_q;
`ifdef NPE_SEQ_PERF_EN
    assign o_stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_npe_conv_seq.sv
// -----------------------------------------------------------------------------
// tb_npe_conv_seq
// Bench for npe_conv_seq. Each scenario is described by per-cycle stimulus
// arrays indexed from the start cycle (k=0). A schedule model derives the
// expected event times (request beats, strobes, done) from the layer rules,
// and one compare task walks the cycles checking every output.
// -----------------------------------------------------------------------------
module tb_npe_conv_seq;
    localparam int CNT_W = 16;
    localparam int MAXC  = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       cfg_mode = '0;
    logic [2:0]       cfg_pe_num = '0;
    logic [CNT_W-1:0] cfg_acc_len = '0;
    logic [CNT_W-1:0] cfg_out_cnt = '0;
    logic             data_rdy = 1'b0;
    logic             res_vld = 1'b0;

    logic       busy, done, cfg_err, mdata_req, conv_out, fc_out, max_out;
    logic [2:0] npe_mode;
    logic [6:0] pe_en;
`ifdef NPE_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    npe_conv_seq #(.CNT_W(CNT_W), .NUM_MAC(7)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_start          (start),
        .i_cfg_mode       (cfg_mode),
        .i_cfg_pe_num     (cfg_pe_num),
        .i_cfg_acc_len    (cfg_acc_len),
        .i_cfg_out_cnt    (cfg_out_cnt),
        .i_data_rdy       (data_rdy),
        .i_npe_result_vld (res_vld),
        .o_busy           (busy),
        .o_done           (done),
        .o_cfg_err        (cfg_err),
        .o_npe_mode       (npe_mode),
        .o_pe_en          (pe_en),
        .o_mdata_req      (mdata_req),
        .o_pe_conv_out    (conv_out),
        .o_pe_fc_out      (fc_out),
        .o_pe_max_out     (max_out)
`ifdef NPE_SEQ_PERF_EN
        ,
        .o_stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scenario description and model outputs
    int t_mode, t_pe, t_acc, t_out;
    bit t_legal;
    int n_cycles, m_done;
    bit rdy_a[MAXC], vld_a[MAXC], st_a[MAXC];
    bit e_busy[MAXC], e_done[MAXC], e_err[MAXC], e_req[MAXC];
    bit e_conv[MAXC], e_fc[MAXC], e_max[MAXC];
    int e_stall[MAXC];

    // Observations of the DUT during a run
    int req_seen, conv_seen, fc_seen, max_seen, err_seen, busy_seen;
    int first_req, last_req, strobe0, strobe1, done_at;
    logic [6:0] pe_en_k1;

    // Build stimulus and expected per-cycle outputs for one layer.
    task automatic setup(input int mode, input int pe, input int acc, input int out,
                         input bit toggle);
        int pes, t, reach, cum, stalls;
        int strobes[$];
        bit stall_ev[MAXC];
        t_mode = mode; t_pe = pe; t_acc = acc; t_out = out;
        for (int k = 0; k < MAXC; k++) begin
            rdy_a[k] = toggle ? (k % 2 == 1) : 1'b1;
            vld_a[k] = 0; st_a[k] = 0; stall_ev[k] = 0;
            e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0; e_req[k] = 0;
            e_conv[k] = 0; e_fc[k] = 0; e_max[k] = 0; e_stall[k] = 0;
        end
        st_a[0] = 1;
        t_legal = (mode == 1 || mode == 2 || mode == 4 || mode == 5) &&
                  acc > 0 && out > 0 && !(mode == 1 && pe == 0);
        m_done = -1;
        if (!t_legal) begin
            e_err[1] = 1;
            n_cycles = 4;
            return;
        end
        pes = (mode == 1) ? pe : 1;
        // Groups: acc beats (skipping stall cycles), then a strobe and pes flush cycles.
        t = 1;
        for (int g = 0; g < out; g++) begin
            int beats = 0;
            while (beats < acc) begin
                if (rdy_a[t]) begin e_req[t] = 1; beats++; end
                else stall_ev[t] = 1;
                t++;
            end
            strobes.push_back(t);
            if (mode == 1) e_conv[t] = 1;
            else if (mode == 2) e_fc[t] = 1;
            else e_max[t] = 1;
            t += pes;
        end
        // The PE controller returns pes result beats right after each strobe.
        foreach (strobes[i])
            for (int j = 1; j <= pes; j++) vld_a[strobes[i] + j] = 1;
        cum = 0; reach = -1;
        for (int c = 1; c < MAXC; c++) begin
            cum += vld_a[c];
            if (cum >= out * pes && reach < 0) reach = c;
        end
        m_done = ((t > reach) ? t : reach) + 1;
        for (int k = 1; k <= m_done; k++) e_busy[k] = 1;
        e_done[m_done] = 1;
        stalls = 0;
        for (int k = 1; k < MAXC; k++) begin
            e_stall[k] = stalls;
            stalls += stall_ev[k];
        end
        n_cycles = m_done + 3;
    endtask

    // Drive the scenario and compare every cycle; abort_at >= 0 pulls reset there.
    task automatic run_test(input string tag, input int abort_at);
        logic [6:0] mask;
        req_seen = 0; conv_seen = 0; fc_seen = 0; max_seen = 0; err_seen = 0;
        busy_seen = 0; first_req = -1; last_req = -1; strobe0 = -1; strobe1 = -1;
        done_at = -1; pe_en_k1 = '0;
        mask = (t_mode == 1) ? 7'((1 << t_pe) - 1) : 7'd1;
        for (int k = 0; k < n_cycles; k++) begin
            @(negedge clk);
            start = st_a[k];
            if (k == 0) begin
                cfg_mode = 3'(t_mode); cfg_pe_num = 3'(t_pe);
                cfg_acc_len = CNT_W'(t_acc); cfg_out_cnt = CNT_W'(t_out);
            end else begin
                // Different legal config afterwards: the latched one must hold.
                cfg_mode = 3'd2; cfg_pe_num = 3'd7;
                cfg_acc_len = CNT_W'(1); cfg_out_cnt = CNT_W'(1);
            end
            data_rdy = rdy_a[k];
            res_vld  = vld_a[k];
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst busy"}, 64'(busy), 0);
                check({tag, " rst done"}, 64'(done), 0);
                check({tag, " rst cfg_err"}, 64'(cfg_err), 0);
                check({tag, " rst mode"}, 64'(npe_mode), 0);
                check({tag, " rst pe_en"}, 64'(pe_en), 0);
                check({tag, " rst req"}, 64'(mdata_req), 0);
                check({tag, " rst strobes"}, 64'({conv_out, fc_out, max_out}), 0);
`ifdef NPE_SEQ_PERF_EN
                check({tag, " rst stall"}, 64'(stall_cnt), 0);
`endif
                start = 0; data_rdy = 0; res_vld = 0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            #1;
            check($sformatf("%s busy@%0d", tag, k), 64'(busy), 64'(e_busy[k]));
            check($sformatf("%s done@%0d", tag, k), 64'(done), 64'(e_done[k]));
            check($sformatf("%s cfg_err@%0d", tag, k), 64'(cfg_err), 64'(e_err[k]));
            check($sformatf("%s mode@%0d", tag, k), 64'(npe_mode),
                  64'(e_busy[k] ? t_mode : 0));
            check($sformatf("%s pe_en@%0d", tag, k), 64'(pe_en),
                  64'(e_busy[k] ? mask : 7'd0));
            check($sformatf("%s req@%0d", tag, k), 64'(mdata_req), 64'(e_req[k]));
            check($sformatf("%s conv@%0d", tag, k), 64'(conv_out), 64'(e_conv[k]));
            check($sformatf("%s fc@%0d", tag, k), 64'(fc_out), 64'(e_fc[k]));
            check($sformatf("%s max@%0d", tag, k), 64'(max_out), 64'(e_max[k]));
`ifdef NPE_SEQ_PERF_EN
            if (t_legal && k >= 1)
                check($sformatf("%s stall@%0d", tag, k), 64'(stall_cnt), 64'(e_stall[k]));
`endif
            if (mdata_req) begin
                req_seen++;
                if (first_req < 0) first_req = k;
                last_req = k;
            end
            if (conv_out || fc_out || max_out) begin
                if (strobe0 < 0) strobe0 = k; else if (strobe1 < 0) strobe1 = k;
            end
            conv_seen += conv_out; fc_seen += fc_out; max_seen += max_out;
            err_seen += cfg_err; busy_seen += busy;
            if (done) done_at = k;
            if (k == 1) pe_en_k1 = pe_en;
        end
        start = 0; data_rdy = 0; res_vld = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("reset busy", 64'(busy), 0);
        check("reset done", 64'(done), 0);
        check("reset pe_en", 64'(pe_en), 0);
        check("reset mode", 64'(npe_mode), 0);
        check("reset strobes", 64'({conv_out, fc_out, max_out, cfg_err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // mac, pe_num=3, acc_len=4, out_cnt=2; restarts while busy are ignored
        setup(1, 3, 4, 2, 0);
        st_a[3] = 1; st_a[9] = 1;
        check("mac model done cycle", 64'(m_done), 16);
        run_test("mac", -1);
        check("mac req count", 64'(req_seen), 8);
        check("mac conv count", 64'(conv_seen), 2);
        check("mac first conv", 64'(strobe0), 5);
        check("mac conv spacing", 64'(strobe1 - strobe0), 7);
        check("mac pe_en", 64'(pe_en_k1), 64'(7'b0000111));
        check("mac done cycle", 64'(done_at), 16);

        // fc, acc_len=1, out_cnt=3, plus a stray result beat while idle
        setup(2, 5, 1, 3, 0);
        vld_a[0] = 1;
        run_test("fc", -1);
        check("fc strobe count", 64'(fc_seen), 3);
        check("fc pe_en", 64'(pe_en_k1), 64'(7'b0000001));
        check("fc done cycle", 64'(done_at), 8);

        // max, acc_len=4, out_cnt=1, data_rdy toggling
        setup(4, 0, 4, 1, 1);
        run_test("max", -1);
        check("max req count", 64'(req_seen), 4);
        check("max req span", 64'(last_req - first_req + 1), 7);
        check("max strobe count", 64'(max_seen), 1);
        check("max done cycle", 64'(done_at), 10);
`ifdef NPE_SEQ_PERF_EN
        check("max stall count", 64'(stall_cnt), 3);
`endif

        // acc mode shares the max strobe
        setup(5, 0, 2, 2, 0);
        run_test("acc", -1);
        check("acc strobe count", 64'(max_seen), 2);

        // illegal configurations
        setup(3, 1, 2, 1, 0);
        run_test("bad_mode", -1);
        check("bad_mode err pulses", 64'(err_seen), 1);
        check("bad_mode busy cycles", 64'(busy_seen), 0);
        check("bad_mode reqs", 64'(req_seen), 0);
        setup(1, 2, 0, 1, 0);
        run_test("acc_zero", -1);
        check("acc_zero err pulses", 64'(err_seen), 1);
        check("acc_zero reqs", 64'(req_seen), 0);
        setup(1, 0, 2, 1, 0);
        run_test("pe_zero", -1);
        check("pe_zero err pulses", 64'(err_seen), 1);

        // reset while the first strobe is out (FLUSH), then a fresh layer
        setup(1, 2, 2, 2, 0);
        run_test("abort", 3);
        setup(1, 7, 3, 2, 0);
        run_test("mac7", -1);
        check("mac7 req count", 64'(req_seen), 6);
        check("mac7 pe_en", 64'(pe_en_k1), 64'(7'b1111111));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
